video_timing: RTL and testbench



---
 rtl/video_pkg.sv | 32 +++
 rtl/video_timing_if.sv | 33 +++
 rtl/video_axis_counter.sv | 70 +++++++
 rtl/video_timing.sv | 122 ++++++++++++
 tb/tb_video_timing.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared types and mode constants for the raster timing controller.
// Default mode is 640x480@60 with active-low syncs.
package video_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } axis_state_t;

  localparam int MODE_H_ACTIVE = 640;
  localparam int MODE_H_FRONT  = 16;
  localparam int MODE_H_SYNC   = 96;
  localparam int MODE_H_BACK   = 48;
  localparam int MODE_V_ACTIVE = 480;
  localparam int MODE_V_FRONT  = 10;
  localparam int MODE_V_SYNC   = 2;
  localparam int MODE_V_BACK   = 33;
  localparam int MODE_HSYNC_POL = 0;
  localparam int MODE_VSYNC_POL = 0;

  function automatic int axis_total(
    input int a,
    input int f,
    input int s,
    input int b
  );
    return a + f + s + b;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Pixel-timing bundle from the raster controller to the pixel generator.
// All members are registered by the master and describe the same pixel.
interface video_timing_if #(
  parameter int XW = 10,
  parameter int YW = 9
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active;
  logic          hsync;
  logic          vsync;
  logic          frame_start;

  modport master (
    output x,
    output y,
    output active,
    output hsync,
    output vsync,
    output frame_start
  );

  modport slave (
    input x,
    input y,
    input active,
    input hsync,
    input vsync,
    input frame_start
  );

endinterface

// File: rtl/video_axis_counter.sv
// One raster axis: ACTIVE/FRONT/SYNC/BACK sequencer plus position counter.
// Zero-length porches are skipped; wrap flags the last tick of the axis.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [W-1:0] len_active,
  input  logic [W-1:0] len_front,
  input  logic [W-1:0] len_sync,
  input  logic [W-1:0] len_back,
  output axis_state_t state,
  output logic [W-1:0] pos,
  output logic        wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] seg;
  logic [W-1:0] cur_len;
  logic         last;
  axis_state_t  nxt;

  // Length of the current segment, successor state and axis wrap.
  always_comb begin
    cur_len = len_active;
    nxt     = state;
    unique case (state)
      ACTIVE: begin
        cur_len = len_active;
        nxt     = (len_front != '0) ? FRONT : SYNC;
      end
      FRONT: begin
        cur_len = len_front;
        nxt     = SYNC;
      end
      SYNC: begin
        cur_len = len_sync;
        nxt     = (len_back != '0) ? BACK : ACTIVE;
      end
      BACK: begin
        cur_len = len_back;
        nxt     = ACTIVE;
      end
    endcase
    last = (seg == cur_len - ONE);
    wrap = tick && last && (nxt == ACTIVE);
  end

  // Segment and position counters advance on each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACTIVE;
      seg   <= '0;
      pos   <= '0;
    end else if (tick) begin
      if (last) begin
        state <= nxt;
        seg   <= '0;
      end else begin
        seg <= seg + ONE;
      end
      pos <= wrap ? '0 : pos + ONE;
    end
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing controller: registered x/y/active/hsync/vsync/frame_start.
// Define VIDEO_TIMING_CE_EN to add the pix_ce pixel advance enable.
module video_timing
  import video_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = MODE_H_ACTIVE,
  parameter int HOR_FRONT_PORCH   = MODE_H_FRONT,
  parameter int HOR_SYNC_PULSE    = MODE_H_SYNC,
  parameter int HOR_BACK_PORCH    = MODE_H_BACK,
  parameter int VER_ACTIVE_PIXELS = MODE_V_ACTIVE,
  parameter int VER_FRONT_PORCH   = MODE_V_FRONT,
  parameter int VER_SYNC_PULSE    = MODE_V_SYNC,
  parameter int VER_BACK_PORCH    = MODE_V_BACK,
  parameter bit HSYNC_POL         = 1'(MODE_HSYNC_POL),
  parameter bit VSYNC_POL         = 1'(MODE_VSYNC_POL)
) (
  input logic clk,
  input logic rst,
`ifdef VIDEO_TIMING_CE_EN
  input logic pix_ce,
`endif
  video_timing_if.master vif
);

  localparam int H_TOTAL = axis_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH,
                                      HOR_SYNC_PULSE, HOR_BACK_PORCH);
  localparam int V_TOTAL = axis_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH,
                                      VER_SYNC_PULSE, VER_BACK_PORCH);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(HOR_ACTIVE_PIXELS);
  localparam int YW = $clog2(VER_ACTIVE_PIXELS);

  if (HOR_ACTIVE_PIXELS < 1 || HOR_SYNC_PULSE < 1 ||
      VER_ACTIVE_PIXELS < 1 || VER_SYNC_PULSE < 1) begin : g_bad_mode
    $error("video_timing: ACTIVE and SYNC lengths must be non-zero");
  end

  logic          tick;
  axis_state_t   hstate;
  axis_state_t   vstate;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          hwrap;
  logic          vwrap;

`ifdef VIDEO_TIMING_CE_EN
  assign tick = pix_ce;
`else
  assign tick = 1'b1;
`endif

  video_axis_counter #(
    .W(HW)
  ) u_h (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .len_active(HW'(HOR_ACTIVE_PIXELS)),
    .len_front (HW'(HOR_FRONT_PORCH)),
    .len_sync  (HW'(HOR_SYNC_PULSE)),
    .len_back  (HW'(HOR_BACK_PORCH)),
    .state     (hstate),
    .pos       (hpos),
    .wrap      (hwrap)
  );

  video_axis_counter #(
    .W(VW)
  ) u_v (
    .clk       (clk),
    .rst       (rst),
    .tick      (hwrap),
    .len_active(VW'(VER_ACTIVE_PIXELS)),
    .len_front (VW'(VER_FRONT_PORCH)),
    .len_sync  (VW'(VER_SYNC_PULSE)),
    .len_back  (VW'(VER_BACK_PORCH)),
    .state     (vstate),
    .pos       (vpos),
    .wrap      (vwrap)
  );

  // A frame can only end on the last tick of a line.
  a_frame_wrap : assert property (@(posedge clk) vwrap |-> hwrap);

  logic          act_n;
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic          hs_n;
  logic          vs_n;
  logic          fs_n;

  // Decode the pixel the counters point at before this tick.
  always_comb begin
    act_n = (hstate == ACTIVE) && (vstate == ACTIVE);
    x_n   = act_n ? XW'(hpos) : '0;
    y_n   = act_n ? YW'(vpos) : '0;
    hs_n  = (hstate == SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vs_n  = (vstate == SYNC) ? VSYNC_POL : ~VSYNC_POL;
    fs_n  = (hpos == '0) && (vpos == '0);
  end

  // Output registers load on the same tick that moves the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      vif.x           <= '0;
      vif.y           <= '0;
      vif.active      <= 1'b0;
      vif.hsync       <= ~HSYNC_POL;
      vif.vsync       <= ~VSYNC_POL;
      vif.frame_start <= 1'b0;
    end else if (tick) begin
      vif.x           <= x_n;
      vif.y           <= y_n;
      vif.active      <= act_n;
      vif.hsync       <= hs_n;
      vif.vsync       <= vs_n;
      vif.frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing in a small 8x6 raster mode.
// A second instance covers the zero front porch line.
module tb_video_timing;

  localparam int HA = 4;
  localparam int HF = 1;
  localparam int HS = 2;
  localparam int HB = 1;
  localparam int VA = 3;
  localparam int VF = 1;
  localparam int VS = 1;
  localparam int VB = 1;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       fs;
  } pix_t;

  localparam pix_t RST_V = '{x: 2'd0, y: 2'd0, active: 1'b0,
                             hsync: 1'b1, vsync: 1'b1, fs: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  logic ce = 1'b1;

  int npass = 0;
  int ntotal = 0;
  int k;
  pix_t q[$];

  video_timing_if #(.XW(2), .YW(2)) va_if ();
  video_timing_if #(.XW(2), .YW(2)) vb_if ();

  video_timing #(
    .HOR_ACTIVE_PIXELS(HA), .HOR_FRONT_PORCH(HF),
    .HOR_SYNC_PULSE(HS), .HOR_BACK_PORCH(HB),
    .VER_ACTIVE_PIXELS(VA), .VER_FRONT_PORCH(VF),
    .VER_SYNC_PULSE(VS), .VER_BACK_PORCH(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_a (
    .clk(clk),
    .rst(rst),
`ifdef VIDEO_TIMING_CE_EN
    .pix_ce(ce),
`endif
    .vif(va_if)
  );

  video_timing #(
    .HOR_ACTIVE_PIXELS(HA), .HOR_FRONT_PORCH(0),
    .HOR_SYNC_PULSE(HS), .HOR_BACK_PORCH(HB),
    .VER_ACTIVE_PIXELS(VA), .VER_FRONT_PORCH(VF),
    .VER_SYNC_PULSE(VS), .VER_BACK_PORCH(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
`ifdef VIDEO_TIMING_CE_EN
    .pix_ce(ce),
`endif
    .vif(vb_if)
  );

  always #5 clk = ~clk;

  function automatic pix_t obs_a();
    pix_t p;
    p = '{va_if.x, va_if.y, va_if.active,
          va_if.hsync, va_if.vsync, va_if.frame_start};
    return p;
  endfunction

  function automatic pix_t obs_b();
    pix_t p;
    p = '{vb_if.x, vb_if.y, vb_if.active,
          vb_if.hsync, vb_if.vsync, vb_if.frame_start};
    return p;
  endfunction

  function automatic pix_t model(input int t,
                                 input int ha, input int hf,
                                 input int hs, input int hb,
                                 input int va, input int vf,
                                 input int vs, input int vb);
    int ht, vt, h, v;
    pix_t p;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h = t % ht;
    v = (t / ht) % vt;
    p.active = (h < ha) && (v < va);
    p.x = p.active ? 2'(h) : 2'd0;
    p.y = p.active ? 2'(v) : 2'd0;
    p.hsync = !((h >= ha + hf) && (h < ha + hf + hs));
    p.vsync = !((v >= va + vf) && (v < va + vf + vs));
    p.fs = (h == 0) && (v == 0);
    return p;
  endfunction

  task automatic test_reset();
    pix_t o;
    rst = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    o = obs_a();
    ntotal++;
    if (o !== RST_V)
      $display("FAIL reset_a got=%b want=%b", o, RST_V);
    else npass++;
    o = obs_b();
    ntotal++;
    if (o !== RST_V)
      $display("FAIL reset_b got=%b want=%b", o, RST_V);
    else npass++;
  endtask

  task automatic test_line_scan();
    pix_t e, o;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 48; i++) begin
      q.push_back(model(k, HA, HF, HS, HB, VA, VF, VS, VB));
      @(posedge clk);
      #1;
      e = q.pop_front();
      o = obs_a();
      ntotal++;
      if (o !== e)
        $display("FAIL line_scan tick=%0d got=%b want=%b", k, o, e);
      else npass++;
      k++;
    end
  endtask

  task automatic test_vblank();
    pix_t e, o;
    for (int i = 0; i < 112; i++) begin
      q.push_back(model(k, HA, HF, HS, HB, VA, VF, VS, VB));
      @(posedge clk);
      #1;
      e = q.pop_front();
      o = obs_a();
      ntotal++;
      if (o !== e)
        $display("FAIL vblank tick=%0d got=%b want=%b", k, o, e);
      else npass++;
      k++;
    end
  endtask

  task automatic test_reset_pulse();
    pix_t e, o;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 19; i++) begin
      q.push_back(model(k, HA, HF, HS, HB, VA, VF, VS, VB));
      @(posedge clk);
      #1;
      e = q.pop_front();
      o = obs_a();
      ntotal++;
      if (o !== e)
        $display("FAIL pre_pulse tick=%0d got=%b want=%b", k, o, e);
      else npass++;
      k++;
    end
    rst = 1'b1;
    q.push_back(RST_V);
    @(posedge clk);
    #1;
    e = q.pop_front();
    o = obs_a();
    ntotal++;
    if (o !== e)
      $display("FAIL in_pulse got=%b want=%b", o, e);
    else npass++;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 24; i++) begin
      q.push_back(model(k, HA, HF, HS, HB, VA, VF, VS, VB));
      @(posedge clk);
      #1;
      e = q.pop_front();
      o = obs_a();
      ntotal++;
      if (o !== e)
        $display("FAIL post_pulse tick=%0d got=%b want=%b", k, o, e);
      else npass++;
      k++;
    end
  endtask

`ifdef VIDEO_TIMING_CE_EN
  task automatic test_ce();
    pix_t e, o, last;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    last = RST_V;
    for (int i = 0; i < 12; i++) begin
      ce = (i % 2 == 0);
      if (ce) begin
        e = model(k, HA, HF, HS, HB, VA, VF, VS, VB);
        k++;
      end else begin
        e = last;
      end
      last = e;
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      o = obs_a();
      ntotal++;
      if (o !== e)
        $display("FAIL ce edge=%0d ce=%0b got=%b want=%b", i, ce, o, e);
      else npass++;
    end
    ce = 1'b1;
  endtask
`endif

  task automatic test_zero_porch();
    pix_t e, o;
    int kb;
    rst_b = 1'b0;
    kb = 0;
    for (int i = 0; i < 21; i++) begin
      q.push_back(model(kb, HA, 0, HS, HB, VA, VF, VS, VB));
      @(posedge clk);
      #1;
      e = q.pop_front();
      o = obs_b();
      ntotal++;
      if (o !== e)
        $display("FAIL zero_porch tick=%0d got=%b want=%b", kb, o, e);
      else npass++;
      kb++;
    end
  endtask

  initial begin
    test_reset();
    test_line_scan();
    test_vblank();
    test_reset_pulse();
`ifdef VIDEO_TIMING_CE_EN
    test_ce();
`endif
    test_zero_porch();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
